// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation codes
// (also used by the ALU control decoder when generating mdu ops) and the
// state encoding of the mdu_iter sequencer.
package mdu_pkg;

    // mdu_op codes; any code not listed behaves as OP_NONE
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mdu_step.sv
// mdu_step
// Combinational single-iteration datapath shared by multiply and divide.
//   is_div   in   select divide step (1) or multiply step (0)
//   opb      in   multiplicand (mult) or divisor (div), unsigned magnitude
//   acc_in   in   mult: {partial product, remaining multiplier bits}
//                 div:  low half holds {remaining dividend, quotient bits}
//   rem_in   in   partial remainder (div only)
//   acc_out  out  accumulator after one step
//   rem_out  out  partial remainder after one step
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     opb,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     rem_in,
    output logic [2*WIDTH-1:0]   acc_out,
    output logic [WIDTH-1:0]     rem_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] quot_sh;

    always_comb begin
        // multiply: add multiplicand to the upper half when the current
        // multiplier bit is set, then shift right keeping the carry
        sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        if (!acc_in[0]) begin
            sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
        end

        // divide: bring the next dividend bit into a WIDTH+1 bit partial
        // remainder and trial-subtract; the extra top bit of diff is the borrow
        shifted = {rem_in, acc_in[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opb};
        quot_sh = {acc_in[WIDTH-2:0], ~diff[WIDTH+1]};

        acc_out = {sum, acc_in[WIDTH-1:1]};
        rem_out = rem_in;
        if (is_div) begin
            acc_out = {acc_in[2*WIDTH-1:WIDTH], quot_sh};
            // the kept remainder is always below the divisor, so WIDTH bits hold it
            rem_out = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles (one bit per cycle); MTHI/MTLO
// write in one cycle.
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while busy=0
//   op     in   mdu_op code, valid with start
//   a      in   rs operand (dividend / multiplicand / MTHI-MTLO source)
//   b      in   rt operand (divisor / multiplier)
//   flush  in   abort in-flight operation
//   busy   out  operation in progress
//   done   out  one-cycle pulse when HI/LO were written by mult/div
//   hi     out  HI register
//   lo     out  LO register
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO written here
// CALC  | one multiply/divide step per cycle, WIDTH steps
// FIX   | sign correction, HI/LO write, done pulse
module mdu_iter import mdu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     a_hold;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 div_zero;

    logic                 op_mult;
    logic                 op_div;
    logic                 op_signed;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        op_mult   = (op == OP_MULT) || (op == OP_MULTU);
        op_div    = (op == OP_DIV)  || (op == OP_DIVU);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        // |MIN| wraps to 2^(WIDTH-1), which is exactly right read as unsigned
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
        prod_fix  = neg_res ? -acc : acc;
        quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -rem : rem;
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .opb     (opb),
        .acc_in  (acc),
        .rem_in  (rem),
        .acc_out (acc_nxt),
        .rem_out (rem_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            opb      <= '0;
            a_hold   <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (op_mult || op_div) begin
                            state    <= ST_CALC;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            is_div   <= op_div;
                            neg_res  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem  <= op_signed && a[WIDTH-1];
                            div_zero <= op_div && (b == '0);
                            a_hold   <= a;
                            rem      <= '0;
                            // mult: multiplicand in opb, multiplier in acc low half
                            // div:  divisor in opb, dividend in acc low half
                            opb      <= op_div ? b_mag : a_mag;
                            acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi <= a_hold;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter
// Directed and random checks of mdu_iter at WIDTH=32 and WIDTH=8 against a
// behavioural model built on native 64-bit arithmetic.
module tb_mdu_iter;
    import mdu_pkg::*;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8, flush8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int   checks;
    int   errors;
    exp_t scb[$];
    exp_t last;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [2:0] o,
                                   input logic [31:0] av, input logic [31:0] bv);
        exp_t r;
        longint unsigned mask, ua, ub, up;
        longint sa, sbv, p, q, m;
        mask = (64'd1 << w) - 64'd1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua | ~mask) : longint'(ua);
        sbv  = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub | ~mask) : longint'(ub);
        r.hi = '0;
        r.lo = '0;
        case (o)
            OP_MULT: begin
                p    = sa * sbv;
                r.hi = (p >> w) & mask;
                r.lo = p & mask;
            end
            OP_MULTU: begin
                up   = ua * ub;
                r.hi = (up >> w) & mask;
                r.lo = up & mask;
            end
            OP_DIV: begin
                if (ub == 0) begin
                    r.hi = ua;
                    r.lo = mask;
                end else begin
                    q    = sa / sbv;
                    m    = sa % sbv;
                    r.hi = m & mask;
                    r.lo = q & mask;
                end
            end
            OP_DIVU: begin
                if (ub == 0) begin
                    r.hi = ua;
                    r.lo = mask;
                end else begin
                    r.hi = (ua % ub) & mask;
                    r.lo = (ua / ub) & mask;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Issue one mult/div, wait for done (bounded) and score HI/LO. Returns in
    // the done cycle so a following call starts back-to-back.
    task automatic run_op(input int w, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] bv);
        int k;
        exp_t e;
        scb.push_back(model(w, o, av, bv));
        if (w == 32) begin
            start = 1'b1; op = o; a = av; b = bv;
        end else begin
            start8 = 1'b1; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
        end
        tick();
        start  = 1'b0;
        start8 = 1'b0;
        chk("busy_after_start", (w == 32) ? busy : busy8, 1'b1);
        k = 0;
        do begin
            tick();
            k++;
        end while (!((w == 32) ? done : done8) && k < w + 4);
        chk("latency", 64'(k), 64'(w + 1));
        chk("busy_in_done", (w == 32) ? busy : busy8, 1'b0);
        e    = scb.pop_front();
        last = e;
        chk("hi", (w == 32) ? 64'(hi) : 64'(hi8), e.hi);
        chk("lo", (w == 32) ? 64'(lo) : 64'(lo8), e.lo);
    endtask

    initial begin
        int   k;
        int   dcount;
        exp_t e;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0; flush = 1'b0; op = OP_NONE; a = '0; b = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = OP_NONE; a8 = '0; b8 = '0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst = 1'b0;
        tick();

        // directed mult/div, chained back-to-back from the done cycle
        run_op(32, OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        tick();
        chk("done_single_pulse", done, 1'b0);
        chk("hi_holds", hi, 32'hFFFF_FFFF);
        run_op(32, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32, OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        run_op(32, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(32, OP_DIVU,  32'h0000_0005, 32'h0000_0000);
        run_op(32, OP_DIV,   32'hFFFF_FFF0, 32'h0000_0000);

        // unused op code is a no-op
        start = 1'b1; op = 3'd7; a = 32'h99;
        tick();
        start = 1'b0;
        chk("unused_op_busy", busy, 1'b0);
        chk("unused_op_hi", hi, last.hi[31:0]);
        chk("unused_op_lo", lo, last.lo[31:0]);

        // MTLO while busy is ignored; MULT result unaffected
        scb.push_back(model(32, OP_MULT, 32'd3, 32'd5));
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        start = 1'b1; op = OP_MTLO; a = 32'h1234;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk("mult_busy_done_seen", done, 1'b1);
        e = scb.pop_front();
        chk("mult_busy_hi", hi, e.hi[31:0]);
        chk("mult_busy_lo", lo, e.lo[31:0]);
        start = 1'b1; op = OP_MTLO; a = 32'h1234;
        tick();
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_busy", busy, 1'b0);
        chk("mtlo_done", done, 1'b0);
        op = OP_MTHI; a = 32'h11;
        tick();
        op = OP_MTLO; a = 32'h22;
        tick();
        start = 1'b0;
        chk("mthi_hi", hi, 32'h11);
        chk("preload_lo", lo, 32'h22);

        // flush during CALC
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        dcount = 0;
        repeat (40) begin
            if (done) dcount++;
            tick();
        end
        chk("flush_no_done", 64'(dcount), 64'd0);
        chk("flush_hi", hi, 32'h11);
        chk("flush_lo", lo, 32'h22);

        // flush in FIX beats the HI/LO write
        start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0;
        repeat (32) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_fix_done", done, 1'b0);
        chk("flush_fix_busy", busy, 1'b0);
        chk("flush_fix_lo", lo, 32'h22);

        // flush with start in IDLE: start ignored
        flush = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'h77;
        tick();
        op = OP_MULT;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush_idle_hi", hi, 32'h11);
        chk("flush_idle_busy", busy, 1'b0);

        // reset mid-operation
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        tick();

        // WIDTH=8 edge cases then random, back-to-back
        run_op(8, OP_DIV,   32'h80, 32'hFF);
        run_op(8, OP_MULT,  32'h80, 32'h80);
        run_op(8, OP_DIVU,  32'hFF, 32'h00);
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            run_op(8, ro, ra, rb);
        end

        // WIDTH=32 random, back-to-back
        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            run_op(32, ro, ra, rb);
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
